// File: rtl/cga_intr_cntlr_lvl_arb.sv
// rtl/cga_intr_cntlr_lvl_arb.sv - CGA interrupt level-change arbiter with PID/PIE masking and four-phase IACK handshake
module cga_intr_cntlr_lvl_arb (
  input  logic        CP,
  input  logic        CLR,
  input  logic [15:0] PID_SET,
  input  logic        SW_CLR,
  input  logic [3:0]  SW_CLR_LVL,
  input  logic [15:0] PIE,
  input  logic [3:0]  PIL,
  input  logic        IACK,
  output logic        INR,
  output logic [3:0]  NLVL,
  output logic [15:0] PID
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] cand;
  logic [3:0]  winner;
  logic        hit;
  logic        ack_clear;
  logic        still_valid;
  logic [15:0] clr_mask;
  logic [15:0] pid_next;

  assign cand = PID & PIE;

  // Ascending scan so the highest set index is the one left in winner.
  always_comb begin
    winner = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (cand[i]) winner = 4'(i);
    end
  end

  assign hit         = (|cand) && (winner > PIL);
  assign ack_clear   = (state == S_REQ) && IACK;
  assign still_valid = PID[NLVL] && PIE[NLVL] && (NLVL > PIL);

  always_comb begin
    clr_mask = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      clr_mask[i] = (SW_CLR && (SW_CLR_LVL == 4'(i))) || (ack_clear && (NLVL == 4'(i)));
    end
  end

  // A set pulse always survives a coincident clear.
  assign pid_next = PID_SET | (PID & ~clr_mask);

  always_ff @(posedge CP) begin
    if (CLR) begin
      PID   <= 16'h0000;
      state <= S_IDLE;
      INR   <= 1'b0;
      NLVL  <= 4'd0;
    end else begin
      PID <= pid_next;
      case (state)
        S_IDLE: begin
          if (hit) begin
            NLVL  <= winner;
            INR   <= 1'b1;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (IACK) begin
            INR   <= 1'b0;
            state <= S_WAIT;
          end else if (!still_valid) begin
            INR   <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (!IACK) state <= S_IDLE;
        end
        default: begin
          INR   <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cga_intr_cntlr_lvl_arb.sv
// tb/tb_cga_intr_cntlr_lvl_arb.sv - directed self-checking bench for cga_intr_cntlr_lvl_arb
module tb_cga_intr_cntlr_lvl_arb;

  logic        CP = 1'b0;
  logic        CLR = 1'b1;
  logic [15:0] PID_SET = 16'h0000;
  logic        SW_CLR = 1'b0;
  logic [3:0]  SW_CLR_LVL = 4'd0;
  logic [15:0] PIE = 16'h0000;
  logic [3:0]  PIL = 4'd0;
  logic        IACK = 1'b0;
  logic        INR;
  logic [3:0]  NLVL;
  logic [15:0] PID;

  int errors = 0;
  int checks = 0;

  cga_intr_cntlr_lvl_arb dut (
    .CP(CP),
    .CLR(CLR),
    .PID_SET(PID_SET),
    .SW_CLR(SW_CLR),
    .SW_CLR_LVL(SW_CLR_LVL),
    .PIE(PIE),
    .PIL(PIL),
    .IACK(IACK),
    .INR(INR),
    .NLVL(NLVL),
    .PID(PID)
  );

  always #5 CP = ~CP;

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with set pulses active: reset must win
    CLR = 1'b1; PID_SET = 16'hFFFF;
    tick(); tick();
    chk("rst_pid", 32'(PID), 32'h0);
    chk("rst_inr", 32'(INR), 32'h0);
    chk("rst_nlvl", 32'(NLVL), 32'h0);
    CLR = 1'b0; PID_SET = 16'h0000;
    tick();
    chk("rel_inr", 32'(INR), 32'h0);
    chk("rel_pid", 32'(PID), 32'h0);

    // Priority between levels 5 and 12
    PIE = 16'hFFFF; PIL = 4'd3;
    PID_SET = 16'h1020;
    tick();
    chk("pri_pid", 32'(PID), 32'h1020);
    chk("pri_inr_k", 32'(INR), 32'h0);
    PID_SET = 16'h0000;
    tick();
    chk("pri_inr", 32'(INR), 32'h1);
    chk("pri_nlvl12", 32'(NLVL), 32'd12);
    IACK = 1'b1;
    tick();
    chk("ack_pid", 32'(PID), 32'h0020);
    chk("ack_inr", 32'(INR), 32'h0);
    IACK = 1'b0;
    tick();
    chk("wait_exit_inr", 32'(INR), 32'h0);
    tick();
    chk("pri2_inr", 32'(INR), 32'h1);
    chk("pri2_nlvl5", 32'(NLVL), 32'd5);
    IACK = 1'b1; tick();
    IACK = 1'b0; tick();
    chk("pri2_pid", 32'(PID), 32'h0);

    // Threshold: level equal to PIL does not request
    PIL = 4'd12; PID_SET = 16'h1000;
    tick();
    PID_SET = 16'h0000;
    tick(); tick();
    chk("thr_inr", 32'(INR), 32'h0);
    chk("thr_pid", 32'(PID), 32'h1000);
    SW_CLR = 1'b1; SW_CLR_LVL = 4'd12;
    tick();
    SW_CLR = 1'b0;
    chk("swclr_pid", 32'(PID), 32'h0);

    // Mask: disabled level 14 waits until enabled
    PIL = 4'd3; PIE = 16'hBFFF; PID_SET = 16'h4000;
    tick();
    PID_SET = 16'h0000;
    tick(); tick();
    chk("mask_inr", 32'(INR), 32'h0);
    chk("mask_pid", 32'(PID), 32'h4000);
    PIE = 16'hFFFF;
    tick();
    chk("unmask_inr", 32'(INR), 32'h1);
    chk("unmask_nlvl", 32'(NLVL), 32'd14);
    tick();
    chk("unmask_hold", 32'(INR), 32'h1);
    IACK = 1'b1; tick();
    IACK = 1'b0; tick();
    chk("unmask_clr", 32'(PID), 32'h0);

    // Withdrawal when the granted level is disabled
    PID_SET = 16'h0400;
    tick();
    PID_SET = 16'h0000;
    tick();
    chk("wd_inr", 32'(INR), 32'h1);
    chk("wd_nlvl", 32'(NLVL), 32'd10);
    PIE = 16'hFBFF;
    tick();
    chk("wd_drop_inr", 32'(INR), 32'h0);
    chk("wd_drop_pid", 32'(PID), 32'h0400);
    PIE = 16'hFFFF;
    tick();
    chk("wd_again_inr", 32'(INR), 32'h1);
    PIE = 16'hFBFF; IACK = 1'b1;
    tick();
    chk("wd_ackwin_pid", 32'(PID), 32'h0);
    chk("wd_ackwin_inr", 32'(INR), 32'h0);
    IACK = 1'b0; PIE = 16'hFFFF;
    tick();

    // Set beats ack clear on the same level
    PID_SET = 16'h0200;
    tick();
    PID_SET = 16'h0000;
    tick();
    chk("col_nlvl", 32'(NLVL), 32'd9);
    IACK = 1'b1; PID_SET = 16'h0200;
    tick();
    chk("col_pid", 32'(PID), 32'h0200);
    chk("col_inr", 32'(INR), 32'h0);
    IACK = 1'b0; PID_SET = 16'h0000;
    tick(); tick();
    chk("col_rereq", 32'(INR), 32'h1);
    chk("col_renlvl", 32'(NLVL), 32'd9);
    IACK = 1'b1; tick();
    IACK = 1'b0; tick();

    // Set beats software clear
    SW_CLR = 1'b1; SW_CLR_LVL = 4'd4; PID_SET = 16'h0010;
    tick();
    chk("swcol_pid", 32'(PID), 32'h0010);
    SW_CLR = 1'b0; PID_SET = 16'h0000;
    tick();
    chk("swcol_nlvl", 32'(NLVL), 32'd4);
    IACK = 1'b1; tick();
    IACK = 1'b0; tick();
    chk("swcol_done", 32'(PID), 32'h0);

    // No preemption by a higher level while in REQ
    PID_SET = 16'h0020;
    tick();
    PID_SET = 16'h0000;
    tick();
    PID_SET = 16'h2000;
    tick();
    PID_SET = 16'h0000;
    chk("nopre_nlvl", 32'(NLVL), 32'd5);
    chk("nopre_inr", 32'(INR), 32'h1);
    IACK = 1'b1; tick();
    chk("nopre_pid", 32'(PID), 32'h2000);
    IACK = 1'b0; tick(); tick();
    chk("nopre_next", 32'(NLVL), 32'd13);
    IACK = 1'b1; tick();
    IACK = 1'b0; tick();

    // IACK in IDLE is ignored
    PID_SET = 16'h0004;
    tick();
    PID_SET = 16'h0000; IACK = 1'b1;
    tick();
    chk("idle_iack_pid", 32'(PID), 32'h0004);
    chk("idle_iack_inr", 32'(INR), 32'h0);
    IACK = 1'b0;
    SW_CLR = 1'b1; SW_CLR_LVL = 4'd2; tick();
    SW_CLR = 1'b0;

    // Four-phase hold: IACK high keeps the arbiter in WAIT
    PID_SET = 16'h0100;
    tick();
    PID_SET = 16'h0000;
    tick();
    chk("hold_nlvl8", 32'(NLVL), 32'd8);
    IACK = 1'b1; PID_SET = 16'h0080;
    tick();
    PID_SET = 16'h0000;
    chk("hold_pid", 32'(PID), 32'h0080);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold_inr%0d", i), 32'(INR), 32'h0);
      tick();
    end
    chk("hold_inr5", 32'(INR), 32'h0);
    IACK = 1'b0;
    tick();
    chk("hold_rel_inr", 32'(INR), 32'h0);
    tick();
    chk("hold_rel_req", 32'(INR), 32'h1);
    chk("hold_rel_nlvl", 32'(NLVL), 32'd7);

    // Reset in the middle of a request
    CLR = 1'b1;
    tick();
    chk("midrst_inr", 32'(INR), 32'h0);
    chk("midrst_pid", 32'(PID), 32'h0);
    chk("midrst_nlvl", 32'(NLVL), 32'h0);
    CLR = 1'b0;
    tick();
    chk("midrst_after", 32'(INR), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
